// File: rtl/psr_pkg.sv
// rtl/psr_pkg.sv - shared PSR flag indices, default width and stack-op decode
package psr_pkg;

    localparam int PSR_FLAG_W = 5;

    localparam int FLAG_C = 4;
    localparam int FLAG_F = 3;
    localparam int FLAG_L = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } stack_op_e;

    // Push and pop together cancel out: the stack is left alone.
    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/psr_lifo.sv
// rtl/psr_lifo.sv - save/restore storage and occupancy count for the PSR stack
module psr_lifo #(
    parameter int FLAG_W = psr_pkg::PSR_FLAG_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [FLAG_W-1:0]          i_wdata,
    output logic [FLAG_W-1:0]          o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [FLAG_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              w_can_push;
    logic              w_can_pop;

    assign w_can_push = (r_count != CNT_W'(DEPTH));
    assign w_can_pop  = (r_count != '0);
    assign o_count    = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && w_can_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == r_count) begin
                    r_mem[i] <= i_wdata;
                end
            end
            r_count <= r_count + CNT_W'(1);
        end else if (i_pop && w_can_pop) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Top of stack is entry count-1; reads zero when empty.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i + 1) == r_count) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/psr_stack.sv
// rtl/psr_stack.sv - masked live PSR register with LIFO save/restore and sticky errors
module psr_stack #(
    parameter int FLAG_W = psr_pkg::PSR_FLAG_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [FLAG_W-1:0]          flags,
    input  logic [FLAG_W-1:0]          wmask,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear_err,
    output logic [FLAG_W-1:0]          flags_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    import psr_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    stack_op_e         w_op;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic [FLAG_W-1:0] w_top;
    logic [FLAG_W-1:0] w_masked;
    logic [CNT_W-1:0]  w_count;

    logic [FLAG_W-1:0] r_flags;
    logic              r_ovf;
    logic              r_unf;

    assign w_op      = decode_op(push, pop);
    assign full      = (w_count == CNT_W'(DEPTH));
    assign empty     = (w_count == '0);
    assign w_push_ok = (w_op == OP_PUSH) && !full;
    assign w_pop_ok  = (w_op == OP_POP)  && !empty;
    assign w_ovf_set = (w_op == OP_PUSH) && full;
    assign w_unf_set = (w_op == OP_POP)  && empty;
    assign w_masked  = (flags & wmask) | (r_flags & ~wmask);

    psr_lifo #(
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH)
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_ok),
        .i_pop   (w_pop_ok),
        .i_wdata (r_flags),
        .o_rdata (w_top),
        .o_count (w_count)
    );

    // A restore from the stack overrides any ALU write in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_pop_ok) begin
            r_flags <= w_top;
        end else if (en) begin
            r_flags <= w_masked;
        end
    end

    // Error set beats clear so a coincident fault is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clear_err) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (clear_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign flags_out = r_flags;
    assign count     = w_count;
    assign ovf_err   = r_ovf;
    assign unf_err   = r_unf;

endmodule

// File: tb/tb_psr_stack.sv
// tb/tb_psr_stack.sv - directed bench for psr_stack with a queue-based reference model
module tb_psr_stack;

    localparam int FW = 5;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [FW-1:0] flags = '0;
    logic [FW-1:0] wmask = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clear_err = 1'b0;
    logic [FW-1:0] flags_out;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          unf_err;

    int checks = 0;
    int errors = 0;

    psr_stack #(.FLAG_W(FW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flags     (flags),
        .wmask     (wmask),
        .push      (push),
        .pop       (pop),
        .clear_err (clear_err),
        .flags_out (flags_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    always #5 clk = ~clk;

    // Reference model: live flags, a queue as the save stack, two sticky bits.
    logic [FW-1:0] stk [$];
    logic [FW-1:0] m_flags = '0;
    logic [FW-1:0] m_next;
    bit            m_ovf = 0;
    bit            m_unf = 0;
    bit            m_restored;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stk.delete();
            m_flags = '0;
            m_ovf   = 0;
            m_unf   = 0;
        end else begin
            m_next     = m_flags;
            m_restored = 0;
            if (clear_err) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (push && !pop) begin
                if (stk.size() == DP) m_ovf = 1;
                else stk.push_back(m_flags);
            end
            if (pop && !push) begin
                if (stk.size() == 0) m_unf = 1;
                else begin
                    m_next     = stk.pop_back();
                    m_restored = 1;
                end
            end
            if (!m_restored && en) m_next = (flags & wmask) | (m_flags & ~wmask);
            m_flags = m_next;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("m.flags_out", int'(flags_out), int'(m_flags));
            chk("m.count",     int'(count),     stk.size());
            chk("m.full",      int'(full),      int'(stk.size() == DP));
            chk("m.empty",     int'(empty),     int'(stk.size() == 0));
            chk("m.ovf_err",   int'(ovf_err),   int'(m_ovf));
            chk("m.unf_err",   int'(unf_err),   int'(m_unf));
        end
    end

    task automatic cyc(input logic e, input logic [FW-1:0] f, input logic [FW-1:0] m,
                       input logic pu, input logic po, input logic cl);
        en = e; flags = f; wmask = m; push = pu; pop = po; clear_err = cl;
        @(posedge clk);
        #1;
        en = 0; push = 0; pop = 0; clear_err = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.flags_out", int'(flags_out), 0);
        chk("rst.count",     int'(count),     0);
        chk("rst.empty",     int'(empty),     1);
        chk("rst.errs",      int'({ovf_err, unf_err}), 0);
        reset = 0;

        // masked write
        cyc(1, 5'b11111, 5'b10001, 0, 0, 0);
        chk("mask.flags", int'(flags_out), 'b10001);

        // nested save/restore
        cyc(1, 5'b10101, 5'b11111, 0, 0, 0);
        cyc(0, 5'b00000, 5'b00000, 1, 0, 0);
        cyc(1, 5'b01010, 5'b11111, 0, 0, 0);
        cyc(0, 5'b00000, 5'b00000, 1, 0, 0);
        cyc(1, 5'b11111, 5'b11111, 0, 0, 0);
        cyc(0, 5'b00000, 5'b00000, 0, 1, 0);
        chk("nest.pop1",  int'(flags_out), 'b01010);
        chk("nest.cnt1",  int'(count),     1);
        cyc(0, 5'b00000, 5'b00000, 0, 1, 0);
        chk("nest.pop2",  int'(flags_out), 'b10101);
        chk("nest.empty", int'(empty),     1);

        // overflow: five pushes each with a live write
        cyc(1, 5'b00001, 5'b11111, 1, 0, 0);
        cyc(1, 5'b00010, 5'b11111, 1, 0, 0);
        cyc(1, 5'b00100, 5'b11111, 1, 0, 0);
        cyc(1, 5'b01000, 5'b11111, 1, 0, 0);
        cyc(1, 5'b10000, 5'b11111, 1, 0, 0);
        chk("ovf.count", int'(count),     4);
        chk("ovf.full",  int'(full),      1);
        chk("ovf.err",   int'(ovf_err),   1);
        chk("ovf.flags", int'(flags_out), 'b10000);
        cyc(0, 0, 0, 0, 1, 0); chk("ovf.pop1", int'(flags_out), 'b00100);
        cyc(0, 0, 0, 0, 1, 0); chk("ovf.pop2", int'(flags_out), 'b00010);
        cyc(0, 0, 0, 0, 1, 0); chk("ovf.pop3", int'(flags_out), 'b00001);
        cyc(0, 0, 0, 0, 1, 0); chk("ovf.pop4", int'(flags_out), 'b10101);

        // underflow and pop-over-en priority
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr.ovf", int'(ovf_err), 0);
        cyc(1, 5'b00011, 5'b11111, 0, 1, 0);
        chk("unf.flags", int'(flags_out), 'b00011);
        chk("unf.err",   int'(unf_err),   1);
        chk("unf.count", int'(count),     0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 5'b11100, 5'b11111, 0, 1, 0);
        chk("prio.flags", int'(flags_out), 'b00011);
        chk("prio.count", int'(count),     0);

        // simultaneous push+pop, then clear against a coincident overflow
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 5'b00110, 5'b11111, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 5'b11000, 5'b00011, 1, 1, 0);
        chk("pp.count", int'(count),     2);
        chk("pp.errs",  int'({ovf_err, unf_err}), 0);
        chk("pp.flags", int'(flags_out), 'b00100);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        chk("clrwin.ovf",   int'(ovf_err), 1);
        chk("clrwin.count", int'(count),   4);

        // asynchronous reset between edges
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 5'b11111, 5'b11111, 0, 0, 0);
        chk("pre.count", int'(count),     3);
        chk("pre.flags", int'(flags_out), 'b11111);
        #2;
        reset = 1;
        #1;
        chk("arst.flags", int'(flags_out), 0);
        chk("arst.count", int'(count),     0);
        chk("arst.empty", int'(empty),     1);
        chk("arst.ovf",   int'(ovf_err),   0);
        en = 1; flags = 5'b10101; wmask = 5'b11111; push = 1;
        @(posedge clk);
        #1;
        chk("arst.hold", int'({flags_out, count}), 0);
        reset = 0;
        cyc(1, 5'b01100, 5'b11111, 0, 0, 0);
        chk("post.flags", int'(flags_out), 'b01100);
        chk("post.count", int'(count),     0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psr_stack.md
PSR_STACK -- requirements
Module: psr_stack

Interface
REQ-001 SHALL have parameter FLAG_W, default 5, meaning number of status flags (bit order MSB..LSB: C, F, L, Z, N).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of save/restore stack entries (DEPTH >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  live-register write enable.
REQ-006 SHALL have port flags  input  FLAG_W  new flag values from the ALU.
REQ-007 SHALL have port wmask  input  FLAG_W  per-flag write mask; 1 = flag written when en.
REQ-008 SHALL have port push  input  1  save the live flags onto the stack (interrupt/call entry).
REQ-009 SHALL have port pop  input  1  restore the live flags from the stack top (return).
REQ-010 SHALL have port clear_err  input  1  clear the sticky error flags.
REQ-011 SHALL have port flags_out  output  FLAG_W  live PSR value, registered.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied stack entries.
REQ-013 SHALL have port full  output  1  high when count == DEPTH.
REQ-014 SHALL have port empty  output  1  high when count == 0.
REQ-015 SHALL have port ovf_err  output  1  sticky: push attempted while full.
REQ-016 SHALL have port unf_err  output  1  sticky: pop attempted while empty.

Function
REQ-017 SHALL, when en and no effective pop, load flags_out <= (flags & wmask) | (flags_out & ~wmask) at the next rising edge (1-cycle latency).
REQ-018 SHALL hold flags_out unchanged when neither en nor an effective pop occurs.
REQ-019 SHALL, on push with full low and pop low, write the pre-edge flags_out into entry count and increment count; an en in the same cycle still updates flags_out per REQ-017.
REQ-020 SHALL, on pop with empty low and push low, load flags_out from entry count-1 and decrement count; pop has priority over en (en ignored that cycle).
REQ-021 SHALL, on push while full, leave stack and count unchanged, set ovf_err, and still apply en.
REQ-022 SHALL, on pop while empty, leave flags_out and count unchanged except for en, and set unf_err.
REQ-023 SHALL, on push and pop asserted together, leave stack and count unchanged, raise no error, and apply en normally.
REQ-024 SHALL derive full and empty combinationally from count; count never exceeds DEPTH and never wraps below 0.
REQ-025 SHALL clear ovf_err/unf_err on clear_err; a set condition in the same cycle wins over clear.
REQ-026 SHALL treat the stack as a LIFO: the Nth pop returns the value saved by the Nth most recent unmatched push.

Reset
REQ-027 SHALL, while reset is high, asynchronously force flags_out=0, count=0, ovf_err=0, unf_err=0 and all stack entries to 0, regardless of clk.
REQ-028 SHALL, on reset assertion mid-operation, discard any push/pop/en of that cycle; normal operation resumes at the first rising edge after reset deasserts.

Structure
REQ-029 SHALL take flag bit-index constants (FLAG_C=4, FLAG_F=3, FLAG_L=2, FLAG_Z=1, FLAG_N=0) and the default FLAG_W from shared package psr_pkg.
REQ-030 SHALL place stack storage and the count pointer in one sub-module psr_lifo (parameters FLAG_W, DEPTH); the masked live register and error logic stay in psr_stack.

Verification
REQ-031 SHALL cover masked write: flags_out=5'b00000, en=1, flags=5'b11111, wmask=5'b10001 -> flags_out=5'b10001 next cycle.
REQ-032 SHALL cover nested save/restore: set 5'b10101, push; set 5'b01010, push; set 5'b11111; pop -> 5'b01010, count=1; pop -> 5'b10101, empty=1.
REQ-033 SHALL cover overflow: DEPTH=4, five pushes -> count=4, full=1, ovf_err=1; four pops return saved values in reverse order.
REQ-034 SHALL cover underflow and priority: pop with empty=1 and en=1, flags=5'b00011, wmask=5'b11111 -> flags_out=5'b00011, unf_err=1; pop with count=1 and en=1 -> restored value wins.
REQ-035 SHALL cover simultaneous push+pop with count=2 -> count stays 2, no error; and clear_err with a coincident overflow -> ovf_err stays 1.
REQ-036 SHALL cover asynchronous reset asserted between clock edges with count=3, flags_out=5'b11111 -> outputs 0, empty=1 immediately, before the next edge.
